// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Scans an 8-digit common-anode seven-segment display with the 32-bit value
//   from out_port0, one hex nibble per digit. A prescaler sets how long each
//   digit slot lasts. The displayed value is a shadow copy that is reloaded
//   only when the last digit slot ends, so a CPU write in the middle of a scan
//   never shows a half-old, half-new value.
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, a digit i>0 is blanked when it and every more-significant
//   shadow nibble are zero. Digit 0 always shows. Anodes and the decimal point
//   are unaffected. When undefined, every digit is decoded.
//
// Parameters
//   SCAN_DIV    io_clk cycles per digit slot (2 .. 2**20)
//   NUM_DIGITS  number of digits scanned (1 .. 8); digit i shows data[4i+3:4i]
//
// Ports
//   io_clk      in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   data_in     in   [31:0] value to display
//   dp_in       in   [7:0]  per-digit decimal point request, 1 = lit
//   enable      in   1 = scanning, 0 = blanked with the scan frozen
//   an_n        out  [7:0]  digit anodes, active-low, at most one low
//   seg_n       out  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp_n        out  decimal point, active-low
//   frame_done  out  one-cycle pulse when the last digit slot of a frame ends

module seg7_scan_display #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        enable,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int unsigned    PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]     IDX_LAST   = 3'(NUM_DIGITS - 1);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    cur_nib;
  logic          cur_blank;

  // Slot timing: the prescaler only advances while enabled, so a pause
  // resumes the same digit with whatever part of its slot was left.
  always_comb begin
    tick = enable && (presc_q == PRESC_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    presc_d = presc_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end

    // The shadow is reloaded only as the last slot ends, giving a stable
    // value for the entire following frame.
    shadow_d     = wrap ? data_in : shadow_q;
    shadow_dp_d  = wrap ? dp_in   : shadow_dp_q;
    frame_done_d = wrap;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // lz_blank[i] is set when shadow nibbles i..NUM_DIGITS-1 are all zero.
  // It depends only on the shadow, so it cannot change during a frame.
  logic [7:0] lz_blank;

  always_comb begin
    logic acc;
    acc      = 1'b1;
    lz_blank = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < int'(NUM_DIGITS)) begin
        acc = acc & (shadow_q[4*i +: 4] == 4'h0);
      end
      lz_blank[i] = (i != 0) && acc;
    end
  end

  assign cur_blank = lz_blank[idx_q];
`else
  assign cur_blank = 1'b0;
`endif

  // Outputs are built from the current index and shadow and registered,
  // so they follow the index by one cycle.
  always_comb begin
    cur_nib = shadow_q[{idx_q, 2'b00} +: 4];
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (enable) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 32'h0;
      shadow_dp_q  <= 8'h0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  localparam int SD = 4;
  localparam int ND = 8;
  localparam int FRAME = SD * ND;

  logic        io_clk;
  logic        resetn;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        enable;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  seg7_scan_display #(.SCAN_DIV(SD), .NUM_DIGITS(ND)) dut (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .enable    (enable),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the number of enabled clock edges since reset fully
  // determines the slot position; the shadow is whatever was on the inputs
  // at the last frame end.
  int unsigned ecount;
  logic [31:0] m_shadow;
  logic [7:0]  m_dp;
  int          fd_seen;
  int          fd_model;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  function automatic int model_digit();
    return int'((ecount % FRAME) / SD);
  endfunction

  task automatic model_reset();
    ecount   = 0;
    m_shadow = 32'h0;
    m_dp     = 8'h0;
  endtask

  // One clock: compute what the outputs must be after the edge, clock,
  // then compare 1 time unit later.
  task automatic step();
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    logic [31:0] cap_d;
    logic [7:0]  cap_dp;
    int          d;
    int          nib;
    d      = model_digit();
    cap_d  = data_in;
    cap_dp = dp_in;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (resetn && enable) begin
      e_an  = ~(8'd1 << d);
      nib   = int'((m_shadow >> (4 * d)) % 16);
      e_seg = dec_tab[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d > 0 && (m_shadow >> (4 * d)) == 0) e_seg = 7'h7F;
`endif
      e_dp  = ~m_dp[d];
      e_fd  = ((ecount % FRAME) == FRAME - 1);
    end
    @(posedge io_clk);
    if (resetn) begin
      if (e_fd) begin
        m_shadow = cap_d;
        m_dp     = cap_dp;
        fd_model++;
      end
      if (enable) ecount++;
    end
    #1;
    if (frame_done) fd_seen++;
    check_val("an_n", 32'(an_n), 32'(e_an));
    check_val("seg_n", 32'(seg_n), 32'(e_seg));
    check_val("dp_n", 32'(dp_n), 32'(e_dp));
    check_val("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    resetn  = 1'b0;
    enable  = 1'b1;
    data_in = 32'h0;
    dp_in   = 8'h0;
    fd_seen = 0;
    fd_model = 0;
    model_reset();

    // Reset held with enable high.
    run(3);
    check_val("rst_an", 32'(an_n), 32'hFF);
    check_val("rst_seg", 32'(seg_n), 32'h7F);

    // Scan and decode: frame 1 shows zeros, frame 2 shows the snapshot.
    data_in = 32'h12345678;
    dp_in   = 8'h01;
    resetn  = 1'b1;
    run(33);
    check_val("f2d0_an", 32'(an_n), 32'hFE);
    check_val("f2d0_seg", 32'(seg_n), 32'h00);
    check_val("f2d0_dp", 32'(dp_n), 32'h0);
    run(4);
    check_val("f2d1_an", 32'(an_n), 32'hFD);
    check_val("f2d1_seg", 32'(seg_n), 32'h78);
    run(24);
    check_val("f2d7_an", 32'(an_n), 32'h7F);
    check_val("f2d7_seg", 32'(seg_n), 32'h79);
    run(3);

    // Tear-free: new value mid-frame only appears in the next frame.
    run(13);
    data_in = 32'hFFFFFFFF;
    run(4);
    check_val("tear_d4_seg", 32'(seg_n), 32'h19);
    run(16);
    check_val("new_d0_seg", 32'(seg_n), 32'h0E);
    run(31);

    // Enable pause in the middle of digit 2.
    run(9);
    enable = 1'b0;
    run(1);
    check_val("pause_an", 32'(an_n), 32'hFF);
    run(9);
    enable = 1'b1;
    run(40);

    // Frame pulse count over five frames.
    fd_seen = 0;
    run(5 * FRAME);
    check_val("fd_count5", 32'(fd_seen), 32'd5);

    // Randomized data, decimal points and enable.
    fd_seen  = 0;
    fd_model = 0;
    for (int i = 0; i < 700; i++) begin
      data_in = $urandom;
      dp_in   = 8'($urandom);
      enable  = ($urandom_range(0, 7) != 0);
      step();
    end
    check_val("fd_count_rand", 32'(fd_seen), 32'(fd_model));

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    enable  = 1'b1;
    data_in = 32'h000000A5;
    run(2 * FRAME);
    data_in = 32'h0;
    run(2 * FRAME);
`endif

    // Asynchronous reset in the middle of a frame, away from a clock edge.
    enable  = 1'b1;
    data_in = 32'hCAFE0123;
    run(5);
    #2;
    resetn = 1'b0;
    #1;
    check_val("arst_an", 32'(an_n), 32'hFF);
    check_val("arst_seg", 32'(seg_n), 32'h7F);
    check_val("arst_dp", 32'(dp_n), 32'h1);
    check_val("arst_fd", 32'(frame_done), 32'h0);
    model_reset();
    run(2);
    resetn = 1'b1;
    run(FRAME + 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
